hazard_flush_ctrl: RTL

- Central stall/flush controller for the 5-stage 64-bit pipeline.
- Drives the write-enables and flush strobes of the PC register and the IF/ID, ID/EX and EX/MEM pipeline registers.
- Arbitrates between three event sources: taken branch redirect (resolved in MEM), load-use data hazard (detected in ID), and instruction-memory wait states.
- Also sequences post-reset pipeline fill, and keeps saturating stall/flush counters plus a fetch-timeout watchdog.

---
 rtl/hazard_flush_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/hazard_flush_ctrl.sv
// Stall/flush arbiter for the 5-stage pipeline: boot fill, branch redirect,
// load-use bubble and imem wait handling, plus event counters and fetch watchdog.
module hazard_flush_ctrl #(
  parameter int BOOT_CYCLES  = 3,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcsrc,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rd,
  input  logic [4:0]  ifid_rs1,
  input  logic [4:0]  ifid_rs2,
  input  logic        ifid_uses_rs2,
  input  logic        imem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events,
  output logic        imem_timeout
);

  typedef enum logic [1:0] {BOOT, RUN, IMEM_WAIT} state_t;

  localparam logic [3:0]  BOOT_LAST   = 4'(BOOT_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LIM = 16'(WAIT_TIMEOUT);

  state_t      state, state_nxt;
  logic [3:0]  boot_cnt;
  logic [15:0] wait_cnt, wait_sat;
  logic        lu, wait_clr, wait_inc, flush_inc;

  assign lu = idex_memread && (idex_rd != 5'd0) &&
              ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));

  assign wait_sat = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;

  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b1;
    idex_flush  = 1'b1;
    exmem_flush = 1'b1;
    state_nxt   = state;
    wait_clr    = 1'b0;
    wait_inc    = 1'b0;
    flush_inc   = 1'b0;
    case (state)
      BOOT: begin
        if (boot_cnt == BOOT_LAST) state_nxt = RUN;
      end
      default: begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (pcsrc) begin
          // Redirect wins over everything; the in-flight fetch is dropped.
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          flush_inc   = 1'b1;
          state_nxt   = RUN;
          wait_clr    = 1'b1;
        end else if (lu) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end else if (!imem_ready) begin
          // Bubble enters ID while the back end keeps draining.
          pc_write   = 1'b0;
          ifid_flush = 1'b1;
          state_nxt  = IMEM_WAIT;
          wait_inc   = 1'b1;
        end else begin
          state_nxt = RUN;
          wait_clr  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= BOOT;
      boot_cnt     <= 4'd0;
      wait_cnt     <= 16'd0;
      stall_cycles <= 32'd0;
      flush_events <= 32'd0;
      imem_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == BOOT) boot_cnt <= boot_cnt + 4'd1;
      if (wait_clr)      wait_cnt <= 16'd0;
      else if (wait_inc) wait_cnt <= wait_sat;
      if (wait_inc && (wait_sat >= TIMEOUT_LIM)) imem_timeout <= 1'b1;
      if ((state != BOOT) && !pc_write && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (flush_inc && (flush_events != 32'hFFFF_FFFF))
        flush_events <= flush_events + 32'd1;
    end
  end

endmodule
